// File: rtl/ram_arb_pkg.sv
// Shared types for the two-client RAM arbiter.
//   arb_state_e : arbiter ownership state (IDLE, OWN_A, OWN_B)
//   owner_e     : identity of the client that received the most recent grant
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

endpackage : ram_arb_pkg

// File: rtl/rr_burst_arb.sv
// Round-robin arbiter between two clients with a bounded burst length.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   a_req, b_req  : per-client request
//   a_gnt, b_gnt  : per-client grant, combinational, same cycle as request
// A client keeps winning contention until it has taken MAX_BURST consecutive
// grants; an uncontended client is always granted.
module rr_burst_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  arb_state_e     state;
  owner_e         last_owner;
  logic [CW-1:0]  burst_cnt;

  logic           a_sel;
  logic           b_sel;
  logic           same_owner;
  logic [CW-1:0]  cnt_next;

  // Grant selection
  always_comb begin
    a_sel = 1'b0;
    b_sel = 1'b0;
    if (a_req && !b_req) begin
      a_sel = 1'b1;
    end else if (b_req && !a_req) begin
      b_sel = 1'b1;
    end else if (a_req && b_req) begin
      case (state)
        OWN_A: begin
          if (burst_cnt < MAX_CNT) a_sel = 1'b1;
          else                     b_sel = 1'b1;
        end
        OWN_B: begin
          if (burst_cnt < MAX_CNT) b_sel = 1'b1;
          else                     a_sel = 1'b1;
        end
        default: begin
          if (last_owner == OWNER_B) a_sel = 1'b1;
          else                       b_sel = 1'b1;
        end
      endcase
    end
  end

  // Burst count follow-on: continue (saturating) for the same owner, restart otherwise
  always_comb begin
    same_owner = (a_sel && (state == OWN_A)) || (b_sel && (state == OWN_B));
    cnt_next   = CW'(1);
    if (same_owner) begin
      cnt_next = (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + CW'(1);
    end
  end

  // Grants are held off for the whole time reset is asserted
  assign a_gnt = a_sel & rstn;
  assign b_gnt = b_sel & rstn;

  // Ownership state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_owner <= OWNER_B;
      burst_cnt  <= '0;
    end else if (a_sel) begin
      state      <= OWN_A;
      last_owner <= OWNER_A;
      burst_cnt  <= cnt_next;
    end else if (b_sel) begin
      state      <= OWN_B;
      last_owner <= OWNER_B;
      burst_cnt  <= cnt_next;
    end else begin
      state      <= IDLE;
      burst_cnt  <= '0;
    end
  end

endmodule : rr_burst_arb

// File: rtl/ram_arbiter.sv
// Two-client arbiter/sequencer in front of a single-port synchronous RAM.
// Ports:
//   clk, rstn                         : clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wd            : client A access request
//   a_gnt                             : A accepted this cycle (combinational)
//   a_rvalid                          : A read data on rd this cycle
//   b_*                               : same for client B
//   rd                                : shared read data (from ram_rd)
//   ram_we/ram_re/ram_addr/ram_wd     : RAM command
//   ram_rd                            : RAM read data (1-cycle latency)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR      = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [ADDR-1:0]  a_addr,
  input  logic [WIDTH-1:0] a_wd,
  output logic             a_gnt,
  output logic             a_rvalid,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [ADDR-1:0]  b_addr,
  input  logic [WIDTH-1:0] b_wd,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] rd,
  output logic             ram_we,
  output logic             ram_re,
  output logic [ADDR-1:0]  ram_addr,
  output logic [WIDTH-1:0] ram_wd,
  input  logic [WIDTH-1:0] ram_rd
);

  rr_burst_arb #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  // RAM command mux from the granted client; idle bus is all zero
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = '0;
    ram_wd   = '0;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_re   = ~a_we;
      ram_addr = a_addr;
      ram_wd   = a_wd;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_re   = ~b_we;
      ram_addr = b_addr;
      ram_wd   = b_wd;
    end
  end

  // Read-return strobes track the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  assign rd = ram_rd;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at MAX_BURST=4 with a
// behavioural RAM, one at MAX_BURST=1 for strict alternation.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wd, b_addr, b_wd;

  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] rd, ram_addr, ram_wd, ram_rd;
  logic       ram_we, ram_re;

  logic       d1_a_gnt, d1_a_rvalid, d1_b_gnt, d1_b_rvalid;
  logic [7:0] d1_rd, d1_ram_addr, d1_ram_wd;
  logic [7:0] d1_ram_rd = 8'h00;
  logic       d1_ram_we, d1_ram_re;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WIDTH(8), .ADDR(8), .MAX_BURST(4)) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rd(rd), .ram_we(ram_we), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  ram_arbiter #(.WIDTH(8), .ADDR(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
    .a_gnt(d1_a_gnt), .a_rvalid(d1_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd),
    .b_gnt(d1_b_gnt), .b_rvalid(d1_b_rvalid),
    .rd(d1_rd), .ram_we(d1_ram_we), .ram_re(d1_ram_re),
    .ram_addr(d1_ram_addr), .ram_wd(d1_ram_wd), .ram_rd(d1_ram_rd)
  );

  // Behavioural RAM: unwritten locations read back as addr ^ 0x3C
  function automatic logic [7:0] pat(input logic [7:0] addr);
    return addr ^ 8'h3C;
  endfunction

  logic [7:0]   mem [256];
  logic [255:0] written;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_rd  <= 8'h00;
      written <= '0;
    end else if (ram_we) begin
      written[ram_addr] <= 1'b1;
    end else if (ram_re) begin
      ram_rd <= written[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wd = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wd = bd;
  endtask

  task automatic to_next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check({tag, "_a_gnt"}, a_gnt, 0);
    check({tag, "_b_gnt"}, b_gnt, 0);
    check({tag, "_ram_cmd"}, {ram_we, ram_re, ram_addr}, 0);
    to_next_cycle();
  endtask

  initial begin
    logic       ea;
    logic [7:0] eaddr;
    logic [7:0] exp_cnt;
    logic       ewe;

    // Reset with both clients already requesting
    rstn = 1'b0;
    drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    to_next_cycle();
    rstn = 1'b1;

    // Contended reads: A x4, B x4, A x4
    for (int i = 0; i < 12; i++) begin
      ea = ((i / 4) % 2) == 0;
      drive(1'b1, 1'b0, 8'(8'h20 + i), 8'h00, 1'b1, 1'b0, 8'(8'h40 + i), 8'h00);
      eaddr = ea ? 8'(8'h20 + i) : 8'(8'h40 + i);
      @(negedge clk);
      check("burst_a_gnt", a_gnt, ea);
      check("burst_b_gnt", b_gnt, !ea);
      check("burst_ram_re", {ram_we, ram_re}, 2'b01);
      check("burst_ram_addr", ram_addr, eaddr);
      to_next_cycle();
      check("burst_a_rvalid", a_rvalid, ea);
      check("burst_b_rvalid", b_rvalid, !ea);
      check("burst_rd", rd, pat(eaddr));
    end

    idle_cycle("idle1");
    check("idle1_rvalid", {a_rvalid, b_rvalid}, 0);

    // B alone for 10 cycles: continuous grant, count saturates at 4
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'(8'h60 + i), 8'h00);
      @(negedge clk);
      check("bonly_b_gnt", b_gnt, 1);
      check("bonly_a_gnt", a_gnt, 0);
      to_next_cycle();
      exp_cnt = (i < 3) ? 8'(i + 1) : 8'd4;
      check("bonly_burst_cnt", 32'(dut.u_arb.burst_cnt), 32'(exp_cnt));
      check("bonly_rd", {b_rvalid, rd}, {1'b1, pat(8'(8'h60 + i))});
    end

    // A writes 0x5A @0x10, B reads 0x10 next cycle
    drive(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("wr_a_gnt", a_gnt, 1);
    check("wr_ram_cmd", {ram_we, ram_re, ram_addr, ram_wd}, {2'b10, 8'h10, 8'h5A});
    to_next_cycle();
    check("wr_rvalid", {a_rvalid, b_rvalid}, 0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("raw_b_gnt", b_gnt, 1);
    check("raw_ram_cmd", {ram_we, ram_re, ram_addr}, {2'b01, 8'h10});
    to_next_cycle();
    check("raw_rvalid", {a_rvalid, b_rvalid}, 2'b01);
    check("raw_rd", rd, 8'h5A);

    // From IDLE: A alone, idle gap, then contention goes to B
    idle_cycle("idle2");
    drive(1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("solo_a_gnt", a_gnt, 1);
    to_next_cycle();
    idle_cycle("idle3");
    drive(1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b0, 8'h42, 8'h00);
    @(negedge clk);
    check("fromidle_gnt", {a_gnt, b_gnt}, 2'b01);
    to_next_cycle();
    check("fromidle_burst_cnt", 32'(dut.u_arb.burst_cnt), 1);
    check("fromidle_rd", {b_rvalid, rd}, {1'b1, pat(8'h42)});

    // MAX_BURST=1 instance: strict alternation with mixed read/write
    idle_cycle("idle4");
    for (int i = 0; i < 8; i++) begin
      ea  = (i % 2) == 0;
      ewe = ea ? ((i % 3) == 0) : ((i % 4) == 1);
      drive(1'b1, (i % 3) == 0, 8'(8'h80 + i), 8'(i), 1'b1, (i % 4) == 1, 8'(8'h90 + i), 8'(i));
      @(negedge clk);
      check("alt_a_gnt", d1_a_gnt, ea);
      check("alt_b_gnt", d1_b_gnt, !ea);
      check("alt_ram_we", d1_ram_we, ewe);
      check("alt_we_re_excl", d1_ram_we & d1_ram_re, 0);
      to_next_cycle();
    end

    // Reset pulse while an A read is outstanding
    idle_cycle("idle5");
    drive(1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("pre_rst_a_gnt", a_gnt, 1);
    to_next_cycle();
    check("pre_rst_a_rvalid", a_rvalid, 1);
    drive(1'b1, 1'b0, 8'h23, 8'h00, 1'b1, 1'b0, 8'h43, 8'h00);
    rstn = 1'b0;
    #1;
    check("mid_rst_a_rvalid", a_rvalid, 0);
    check("mid_rst_gnt", {a_gnt, b_gnt, ram_re}, 0);
    to_next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", {a_gnt, b_gnt}, 2'b10);
    to_next_cycle();
    check("post_rst_rd", {a_rvalid, b_rvalid, rd}, {2'b10, pat(8'h23)});

    idle_cycle("idle6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_arbiter
